// File: rtl/matmul_job_sequencer_if.sv
// APB requester bus between matmul_job_sequencer (master) and the matrix_multiplication
// register block (slave).
`ifndef REG_DATAWIDTH
`define REG_DATAWIDTH 16
`endif
`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 8
`endif

interface matmul_job_sequencer_if;
    logic [`REG_ADDRWIDTH-1:0] PADDR;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [`REG_DATAWIDTH-1:0] PWDATA;
    logic [`REG_DATAWIDTH-1:0] PRDATA;
    logic                      PREADY;

    modport master (output PADDR, PWRITE, PSEL, PENABLE, PWDATA, input PRDATA, PREADY);
    modport slave  (input PADDR, PWRITE, PSEL, PENABLE, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/matmul_job_sequencer.sv
// Runs one matrix-multiply job over APB: program operands, start, poll status, clear start.
// Optional poll watchdog is compiled in when SEQ_POLL_TIMEOUT_EN is defined.
`ifndef REG_DATAWIDTH
`define REG_DATAWIDTH 16
`endif
`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 8
`endif

module matmul_job_sequencer #(
    parameter int POLL_GAP       = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [`REG_DATAWIDTH-1:0] job_addr_a,
    input  logic [`REG_DATAWIDTH-1:0] job_addr_b,
    input  logic [`REG_DATAWIDTH-1:0] job_addr_c,
    input  logic [`REG_DATAWIDTH-1:0] job_stride_a,
    input  logic [`REG_DATAWIDTH-1:0] job_stride_b,
    input  logic [`REG_DATAWIDTH-1:0] job_stride_c,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [4:0]                resp_flags,
    output logic                      resp_timeout,
    matmul_job_sequencer_if.master    apb
);
    localparam int DW = `REG_DATAWIDTH;
    localparam int AW = `REG_ADDRWIDTH;
    localparam logic [3:0] STEP_GO    = 4'd6;
    localparam logic [3:0] STEP_POLL  = 4'd7;
    localparam logic [3:0] STEP_CLEAR = 4'd8;
    localparam logic [7:0] GAP_LAST   = 8'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, RESP} state_t;

    state_t         state_reg, state_next;
    logic [3:0]     step_reg, step_next;
    logic [7:0]     gap_cnt_reg, gap_cnt_next;
    logic [4:0]     flags_reg, flags_next;
    logic           timeout_reg, timeout_next;
    logic [DW-1:0]  job_in  [6];
    logic [DW-1:0]  job_reg [6];
    logic           capture;
    logic           timeout_hit;
    logic           unused_prdata;

    assign capture       = (state_reg == IDLE) && job_valid;
    assign unused_prdata = ^{apb.PRDATA[DW-1:6]};

    assign job_in[0] = job_addr_a;
    assign job_in[1] = job_addr_b;
    assign job_in[2] = job_addr_c;
    assign job_in[3] = job_stride_a;
    assign job_in[4] = job_stride_b;
    assign job_in[5] = job_stride_c;

    for (genvar gi = 0; gi < 6; gi++) begin : g_job
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn)      job_reg[gi] <= '0;
            else if (capture) job_reg[gi] <= job_in[gi];
        end
    end

`ifdef SEQ_POLL_TIMEOUT_EN
    // Watchdog counts every busy cycle from capture and saturates; frozen while waiting in RESP.
    logic [31:0] wd_cnt_reg;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            wd_cnt_reg <= '0;
        else if (capture)
            wd_cnt_reg <= '0;
        else if (state_reg != IDLE && state_reg != RESP && wd_cnt_reg != 32'hFFFF_FFFF)
            wd_cnt_reg <= wd_cnt_reg + 32'd1;
    end
    assign timeout_hit = (wd_cnt_reg >= 32'(TIMEOUT_CYCLES));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            step_reg    <= '0;
            gap_cnt_reg <= '0;
            flags_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            step_reg    <= step_next;
            gap_cnt_reg <= gap_cnt_next;
            flags_reg   <= flags_next;
            timeout_reg <= timeout_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        step_next    = step_reg;
        gap_cnt_next = gap_cnt_reg;
        flags_next   = flags_reg;
        timeout_next = timeout_reg;
        case (state_reg)
            IDLE: begin
                if (job_valid) begin
                    state_next   = SETUP;
                    step_next    = '0;
                    gap_cnt_next = '0;
                    flags_next   = '0;
                    timeout_next = 1'b0;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                if (apb.PREADY) begin
                    if (step_reg == STEP_CLEAR) begin
                        state_next = RESP;
                    end else if (step_reg == STEP_POLL && apb.PRDATA[0]) begin
                        // A done poll wins over a watchdog expiring on the same edge.
                        flags_next = apb.PRDATA[5:1];
                        step_next  = STEP_CLEAR;
                        state_next = SETUP;
                    end else if (timeout_hit) begin
                        flags_next   = '0;
                        timeout_next = 1'b1;
                        step_next    = STEP_CLEAR;
                        state_next   = SETUP;
                    end else if (step_reg == STEP_POLL) begin
                        if (POLL_GAP == 0) begin
                            state_next = SETUP;
                        end else begin
                            state_next   = GAP;
                            gap_cnt_next = '0;
                        end
                    end else begin
                        step_next  = step_reg + 4'd1;
                        state_next = SETUP;
                    end
                end
            end
            GAP: begin
                if (timeout_hit) begin
                    flags_next   = '0;
                    timeout_next = 1'b1;
                    step_next    = STEP_CLEAR;
                    state_next   = SETUP;
                end else if (gap_cnt_reg == GAP_LAST) begin
                    state_next = SETUP;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 8'd1;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // APB outputs decode purely from registered state, so they stay frozen through wait states.
    always_comb begin
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
        if (state_reg == SETUP || state_reg == ACCESS) begin
            apb.PSEL    = 1'b1;
            apb.PENABLE = (state_reg == ACCESS);
            apb.PWRITE  = (step_reg != STEP_POLL);
            case (step_reg)
                4'd0:      begin apb.PADDR = AW'(1); apb.PWDATA = job_reg[0]; end
                4'd1:      begin apb.PADDR = AW'(2); apb.PWDATA = job_reg[1]; end
                4'd2:      begin apb.PADDR = AW'(3); apb.PWDATA = job_reg[2]; end
                4'd3:      begin apb.PADDR = AW'(4); apb.PWDATA = job_reg[3]; end
                4'd4:      begin apb.PADDR = AW'(5); apb.PWDATA = job_reg[4]; end
                4'd5:      begin apb.PADDR = AW'(6); apb.PWDATA = job_reg[5]; end
                STEP_GO:   begin apb.PADDR = AW'(0); apb.PWDATA = DW'(1);     end
                STEP_POLL: begin apb.PADDR = AW'(7); apb.PWDATA = '0;         end
                default:   begin apb.PADDR = AW'(0); apb.PWDATA = '0;         end
            endcase
        end
    end

    assign job_ready    = (state_reg == IDLE);
    assign resp_valid   = (state_reg == RESP);
    assign resp_flags   = flags_reg;
    assign resp_timeout = timeout_reg;
endmodule
